// File: rtl/ysyx_25020037_icache_refill_if.sv
// Bundle of the icache refill port and the AXI4 read-address/read-data
// channels used by the refill responder.
// slave  : the refill responder itself.
// master : the environment (icache side plus AXI slave side).
interface ysyx_25020037_icache_refill_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BLOCK_SIZE     = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ID_WIDTH       = 4
);
    logic                      mem_req;
    logic [ADDR_WIDTH-1:0]     mem_addr;
    logic [BLOCK_SIZE*8-1:0]   mem_data;
    logic                      mem_ready;
    logic                      mem_err;

    logic                      arvalid;
    logic                      arready;
    logic [ADDR_WIDTH-1:0]     araddr;
    logic [ID_WIDTH-1:0]       arid;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;

    logic                      rvalid;
    logic                      rready;
    logic [AXI_DATA_WIDTH-1:0] rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic [ID_WIDTH-1:0]       rid;

    modport slave (
        input  mem_req, mem_addr, arready, rvalid, rdata, rresp, rlast, rid,
        output mem_data, mem_ready, mem_err,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready
    );

    modport master (
        output mem_req, mem_addr, arready, rvalid, rdata, rresp, rlast, rid,
        input  mem_data, mem_ready, mem_err,
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready
    );
endinterface

// File: rtl/ysyx_25020037_icache_refill.sv
// icache refill responder: fetches one cache block over AXI4 read and
// returns it in one beat with a single-cycle mem_ready pulse.
// Build option: define YSYX_25020037_ICACHE_BURST_EN to fetch the block with
// one INCR burst; otherwise BEATS single-beat transactions are issued (for
// slaves without burst support).
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for mem_req, latches the block base address
// S_AR   | arvalid held with stable address until arready
// S_R    | rready high, beats written into mem_data in address order
// S_RESP | mem_ready (and mem_err) pulse for exactly one cycle
module ysyx_25020037_icache_refill #(
    parameter int ADDR_WIDTH     = 32,
    parameter int BLOCK_SIZE     = 16,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int ID_WIDTH       = 4,
    parameter int AXI_ID         = 0
) (
    input  logic clk,
    input  logic rst,
    ysyx_25020037_icache_refill_if.slave bus
);
    localparam int BEATS = BLOCK_SIZE * 8 / AXI_DATA_WIDTH;
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

`ifdef YSYX_25020037_ICACHE_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_RESP} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [ADDR_WIDTH-1:0]   araddr_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    err_q;
    logic                    arvalid_q;
    logic                    rready_q;
    logic                    mem_ready_q;
    logic                    mem_err_q;
    logic [BLOCK_SIZE*8-1:0] mem_data_q;

    logic                    beat_fire;
    logic                    beat_last;
    logic                    exp_rlast;
    logic                    beat_err;
    logic [CNT_W-1:0]        cnt_d;
    logic [ADDR_WIDTH-1:0]   next_addr_d;
    logic                    unused_rid;

    // Per-beat decode: handshake, last-beat detect, error and next single-beat address
    always_comb begin
        beat_fire   = bus.rvalid && rready_q;
        beat_last   = (cnt_q == LAST_CNT);
        // Single-beat transactions must each end with rlast; a burst only on the final beat.
        exp_rlast   = BURST_EN ? beat_last : 1'b1;
        beat_err    = (bus.rresp != 2'b00) || (bus.rlast != exp_rlast);
        cnt_d       = cnt_q + 1'b1;
        next_addr_d = base_q + ADDR_WIDTH'(cnt_d) * ADDR_WIDTH'(BYTES);
    end

    assign unused_rid = ^bus.rid;

    // Refill sequencer with registered AXI and icache-side outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            araddr_q    <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            mem_ready_q <= 1'b0;
            mem_err_q   <= 1'b0;
            mem_data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_req) begin
                        base_q    <= bus.mem_addr;
                        araddr_q  <= bus.mem_addr;
                        arvalid_q <= 1'b1;
                        state_q   <= S_AR;
                    end
                end
                S_AR: begin
                    if (bus.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (beat_fire) begin
                        for (int b = 0; b < BEATS; b++) begin
                            if (cnt_q == CNT_W'(b)) begin
                                mem_data_q[b*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= bus.rdata;
                            end
                        end
                        cnt_q <= cnt_d;
                        err_q <= err_q | beat_err;
                        // The beat count alone ends the block; rlast only feeds the error flag.
                        if (beat_last) begin
                            rready_q    <= 1'b0;
                            mem_ready_q <= 1'b1;
                            mem_err_q   <= err_q | beat_err;
                            state_q     <= S_RESP;
                        end else if (!BURST_EN) begin
                            rready_q  <= 1'b0;
                            arvalid_q <= 1'b1;
                            araddr_q  <= next_addr_d;
                            state_q   <= S_AR;
                        end
                    end
                end
                S_RESP: begin
                    mem_ready_q <= 1'b0;
                    mem_err_q   <= 1'b0;
                    cnt_q       <= '0;
                    err_q       <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_data  = mem_data_q;
    assign bus.mem_ready = mem_ready_q;
    assign bus.mem_err   = mem_err_q;
    assign bus.arvalid   = arvalid_q;
    assign bus.araddr    = araddr_q;
    assign bus.arid      = ID_WIDTH'(AXI_ID);
    assign bus.arlen     = BURST_EN ? 8'(BEATS - 1) : 8'd0;
    assign bus.arsize    = 3'($clog2(BYTES));
    assign bus.arburst   = 2'b01;
    assign bus.rready    = rready_q;
endmodule
